// File: rtl/cache_refill_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between I-cache and D-cache line refills.
// Optional CACHE_REFILL_ARB_STATS_EN adds grant and contention counters.
module cache_refill_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic                  ic_gnt_o,
  output logic                  ic_rvalid_o,
  output logic [DATA_WIDTH-1:0] ic_rdata_o,
  output logic                  ic_rlast_o,
  output logic                  ic_err_o,
  input  logic                  dc_req_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  output logic                  dc_gnt_o,
  output logic                  dc_rvalid_o,
  output logic [DATA_WIDTH-1:0] dc_rdata_o,
  output logic                  dc_rlast_o,
  output logic                  dc_err_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef CACHE_REFILL_ARB_STATS_EN
  ,
  output logic [31:0]           ic_grants_o,
  output logic [31:0]           dc_grants_o,
  output logic [31:0]           contend_o
`endif
);

  localparam int unsigned CNT_W      = $clog2(LINE_WORDS) + 1;
  localparam int unsigned LINE_BYTES = LINE_WORDS * DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2  = $clog2(DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic                  OWN_IC    = 1'b0;
  localparam logic                  OWN_DC    = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_owner_q, last_owner_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]   araddr_d;
  logic                    arvalid_d, rready_d;
  logic                    ic_gnt_d, dc_gnt_d;
  logic                    ic_rvalid_d, dc_rvalid_d;
  logic [DATA_WIDTH-1:0]   ic_rdata_d, dc_rdata_d;
  logic                    ic_rlast_d, dc_rlast_d, ic_err_d, dc_err_d;
  logic                    any_req, pick_dc, ar_fire, r_fire, r_deliver, r_last, r_err;

  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;

  // Tie goes to whichever requester did not own the previous burst
  assign any_req   = ic_req_i | dc_req_i;
  assign pick_dc   = dc_req_i & (~ic_req_i | (last_owner_q == OWN_IC));
  assign ar_fire   = (state_q == ADDR) & m_axi_arvalid & m_axi_arready;
  assign r_fire    = (state_q == DATA) & m_axi_rvalid & m_axi_rready;
  // Beats past a full line are sunk without being forwarded
  assign r_deliver = r_fire & (beat_cnt_q != FULL_CNT);
  assign r_last    = (beat_cnt_q == LAST_IDX) | m_axi_rlast;
  assign r_err     = (m_axi_rresp != 2'b00) | (m_axi_rlast != (beat_cnt_q == LAST_IDX));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_IC;
      last_owner_q  <= OWN_DC;
      beat_cnt_q    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      ic_gnt_o      <= 1'b0;
      dc_gnt_o      <= 1'b0;
      ic_rvalid_o   <= 1'b0;
      ic_rdata_o    <= '0;
      ic_rlast_o    <= 1'b0;
      ic_err_o      <= 1'b0;
      dc_rvalid_o   <= 1'b0;
      dc_rdata_o    <= '0;
      dc_rlast_o    <= 1'b0;
      dc_err_o      <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      beat_cnt_q    <= beat_cnt_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      ic_gnt_o      <= ic_gnt_d;
      dc_gnt_o      <= dc_gnt_d;
      ic_rvalid_o   <= ic_rvalid_d;
      ic_rdata_o    <= ic_rdata_d;
      ic_rlast_o    <= ic_rlast_d;
      ic_err_o      <= ic_err_d;
      dc_rvalid_o   <= dc_rvalid_d;
      dc_rdata_o    <= dc_rdata_d;
      dc_rlast_o    <= dc_rlast_d;
      dc_err_o      <= dc_err_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ADDR;
      ADDR:    if (ar_fire) state_d = DATA;
      DATA:    if (r_fire && m_axi_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    araddr_d     = m_axi_araddr;
    arvalid_d    = 1'b0;
    rready_d     = 1'b0;
    ic_gnt_d     = 1'b0;
    dc_gnt_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = pick_dc;
          araddr_d   = (pick_dc ? dc_addr_i : ic_addr_i) & LINE_MASK;
          arvalid_d  = 1'b1;
          ic_gnt_d   = ~pick_dc;
          dc_gnt_d   = pick_dc;
          beat_cnt_d = '0;
        end
      end
      ADDR: begin
        arvalid_d = ~ar_fire;
        rready_d  = ar_fire;
      end
      DATA: begin
        rready_d = ~(r_fire & m_axi_rlast);
        if (r_deliver) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (r_fire && m_axi_rlast) last_owner_d = owner_q;
      end
      default: ;
    endcase

    ic_rvalid_d = r_deliver & (owner_q == OWN_IC);
    dc_rvalid_d = r_deliver & (owner_q == OWN_DC);
    ic_rdata_d  = ic_rvalid_d ? m_axi_rdata : '0;
    dc_rdata_d  = dc_rvalid_d ? m_axi_rdata : '0;
    ic_rlast_d  = ic_rvalid_d & r_last;
    dc_rlast_d  = dc_rvalid_d & r_last;
    ic_err_d    = ic_rvalid_d & r_err;
    dc_err_d    = dc_rvalid_d & r_err;
  end

`ifdef CACHE_REFILL_ARB_STATS_EN
  // Free-running statistics, wrap modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ic_grants_o <= '0;
      dc_grants_o <= '0;
      contend_o   <= '0;
    end else begin
      if (ic_gnt_d) ic_grants_o <= ic_grants_o + 32'd1;
      if (dc_gnt_d) dc_grants_o <= dc_grants_o + 32'd1;
      if ((state_q == IDLE) && ic_req_i && dc_req_i) contend_o <= contend_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboard bench for cache_refill_arbiter: directed refills against a simple AXI read slave model.
module tb_cache_refill_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          ic_req_i, dc_req_i;
  logic [AW-1:0] ic_addr_i, dc_addr_i;
  logic          ic_gnt_o, ic_rvalid_o, ic_rlast_o, ic_err_o;
  logic          dc_gnt_o, dc_rvalid_o, dc_rlast_o, dc_err_o;
  logic [DW-1:0] ic_rdata_o, dc_rdata_o;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
`ifdef CACHE_REFILL_ARB_STATS_EN
  logic [31:0]   ic_grants_o, dc_grants_o, contend_o;
`endif

  cache_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o), .ic_rvalid_o(ic_rvalid_o),
    .ic_rdata_o(ic_rdata_o), .ic_rlast_o(ic_rlast_o), .ic_err_o(ic_err_o),
    .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o),
    .dc_rdata_o(dc_rdata_o), .dc_rlast_o(dc_rlast_o), .dc_err_o(dc_err_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef CACHE_REFILL_ARB_STATS_EN
    , .ic_grants_o(ic_grants_o), .dc_grants_o(dc_grants_o), .contend_o(contend_o)
`endif
  );

  typedef struct { logic [31:0] data; logic last; logic err; } beat_t;
  typedef struct { logic [31:0] addr; int cycles; } ar_t;

  beat_t      ic_q[$];
  beat_t      dc_q[$];
  ar_t        ar_q[$];
  logic [1:0] gnt_q[$];
  int total = 0;
  int bad   = 0;

  int cfg_ar_delay   = 0;
  int cfg_err_beat   = -1;
  int cfg_rlast_beat = LW - 1;
  int sl_state       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no/unexpected event expected a matching event", name);
  endtask

  // Expected grant, AR and beats for one refill; slave data = word address + beat index
  task automatic expect_burst(input int who, input logic [31:0] addr, input int delay,
                              input int err_beat, input int rlast_beat);
    logic [31:0] aligned;
    ar_t a;
    beat_t b;
    aligned = addr & ~(32'(LW * DW / 8) - 32'd1);
    gnt_q.push_back(who == 0 ? 2'b01 : 2'b10);
    a.addr = aligned;
    a.cycles = delay + 1;
    ar_q.push_back(a);
    for (int i = 0; i <= rlast_beat; i++) begin
      b.data = (aligned >> 2) + 32'(i);
      b.last = (i == LW - 1) || (i == rlast_beat);
      b.err  = (i == err_beat) || ((i == rlast_beat) && (rlast_beat != LW - 1));
      if (who == 0) ic_q.push_back(b); else dc_q.push_back(b);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 64'({ic_gnt_o, dc_gnt_o}), 64'd0);
    chk({tag, "_ic_out"}, 64'({ic_rvalid_o, ic_rdata_o, ic_rlast_o, ic_err_o}), 64'd0);
    chk({tag, "_dc_out"}, 64'({dc_rvalid_o, dc_rdata_o, dc_rlast_o, dc_err_o}), 64'd0);
    chk({tag, "_ar_r"}, 64'({m_axi_arvalid, m_axi_rready}), 64'd0);
    chk({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
`ifdef CACHE_REFILL_ARB_STATS_EN
    chk({tag, "_stats"}, 64'(ic_grants_o | dc_grants_o | contend_o), 64'd0);
`endif
  endtask

  task automatic single_req(input int who, input logic [31:0] addr);
    bit got = 0;
    if (who == 0) begin ic_req_i = 1'b1; ic_addr_i = addr; end
    else begin dc_req_i = 1'b1; dc_addr_i = addr; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (who == 0 && ic_gnt_o) begin ic_req_i = 1'b0; got = 1; end
      if (who == 1 && dc_gnt_o) begin dc_req_i = 1'b0; got = 1; end
    end
    if (!got) begin
      ic_req_i = 1'b0; dc_req_i = 1'b0;
      fail_evt("single_req_timeout");
    end
  endtask

  task automatic tie_req(input logic [31:0] ia, input logic [31:0] da);
    ic_req_i = 1'b1; ic_addr_i = ia;
    dc_req_i = 1'b1; dc_addr_i = da;
    for (int i = 0; i < 100 && (ic_req_i || dc_req_i); i++) begin
      @(posedge clk); #1;
      if (ic_gnt_o) ic_req_i = 1'b0;
      if (dc_gnt_o) dc_req_i = 1'b0;
    end
    if (ic_req_i || dc_req_i) begin
      ic_req_i = 1'b0; dc_req_i = 1'b0;
      fail_evt("tie_req_timeout");
    end
  endtask

  task automatic wait_done(input string tag);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (ic_q.size() == 0 && dc_q.size() == 0 && ar_q.size() == 0 && gnt_q.size() == 0 &&
          sl_state == 0 && !m_axi_rready && !m_axi_arvalid) done = 1;
    end
    if (!done) fail_evt({tag, "_done_timeout"});
    @(posedge clk); #1;
  endtask

  // AXI read slave model
  initial begin : slave
    logic ar_hs, r_hs, rst_s;
    logic [31:0] a_s, base;
    int w, beat, eb, lb;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00; m_axi_rdata = '0;
    w = 0; beat = 0; eb = -1; lb = LW - 1; base = '0;
    forever begin
      @(posedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      rst_s = rst_n;
      a_s   = m_axi_araddr;
      #1;
      if (!rst_s) begin
        sl_state = 0; w = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00; m_axi_rdata = '0;
      end else if (sl_state == 0) begin
        if (ar_hs) begin
          m_axi_arready = 1'b0; sl_state = 1; w = 0; beat = 0;
          base = a_s >> 2; eb = cfg_err_beat; lb = cfg_rlast_beat;
          m_axi_rvalid = 1'b1; m_axi_rdata = base;
          m_axi_rresp = (beat == eb) ? 2'b10 : 2'b00; m_axi_rlast = (beat == lb);
        end else if (m_axi_arvalid === 1'b1) begin
          m_axi_arready = (w >= cfg_ar_delay);
          w++;
        end
      end else if (r_hs) begin
        if (m_axi_rlast) begin
          sl_state = 0;
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        end else begin
          beat++;
          m_axi_rdata = base + 32'(beat);
          m_axi_rresp = (beat == eb) ? 2'b10 : 2'b00; m_axi_rlast = (beat == lb);
        end
      end
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT presents an output
  initial begin : monitor
    logic prev_gnt;
    bit ar_active;
    logic [31:0] ar_first;
    int ar_cyc;
    ar_t ea;
    beat_t b;
    prev_gnt = 1'b0; ar_active = 0; ar_first = '0; ar_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_gnt = 1'b0; ar_active = 0;
      end else begin
        if (ic_gnt_o || dc_gnt_o) begin
          chk("gnt_pulse_width", 64'(prev_gnt), 64'd0);
          if (gnt_q.size() == 0) fail_evt("gnt_unexpected");
          else chk("gnt_owner", 64'({dc_gnt_o, ic_gnt_o}), 64'(gnt_q.pop_front()));
        end
        prev_gnt = ic_gnt_o | dc_gnt_o;

        if (m_axi_arvalid) begin
          if (!ar_active) begin
            ar_active = 1; ar_first = m_axi_araddr; ar_cyc = 0;
          end else begin
            chk("araddr_stable", 64'(m_axi_araddr), 64'(ar_first));
          end
          ar_cyc++;
          chk("rready_before_ar", 64'(m_axi_rready), 64'd0);
          if (m_axi_arready) begin
            ar_active = 0;
            if (ar_q.size() == 0) fail_evt("ar_unexpected");
            else begin
              ea = ar_q.pop_front();
              chk("araddr", 64'(m_axi_araddr), 64'(ea.addr));
              chk("arlen_size_burst", 64'({m_axi_arlen, m_axi_arsize, m_axi_arburst}),
                  64'({8'd3, 3'd2, 2'b01}));
              chk("arvalid_cycles", 64'(ar_cyc), 64'(ea.cycles));
            end
          end
        end

        if (ic_rvalid_o) begin
          if (ic_q.size() == 0) fail_evt("ic_beat_unexpected");
          else begin
            b = ic_q.pop_front();
            chk("ic_rdata", 64'(ic_rdata_o), 64'(b.data));
            chk("ic_rlast", 64'(ic_rlast_o), 64'(b.last));
            chk("ic_err", 64'(ic_err_o), 64'(b.err));
          end
          chk("dc_quiet", 64'({dc_rvalid_o, dc_rdata_o, dc_rlast_o, dc_err_o}), 64'd0);
        end
        if (dc_rvalid_o) begin
          if (dc_q.size() == 0) fail_evt("dc_beat_unexpected");
          else begin
            b = dc_q.pop_front();
            chk("dc_rdata", 64'(dc_rdata_o), 64'(b.data));
            chk("dc_rlast", 64'(dc_rlast_o), 64'(b.last));
            chk("dc_err", 64'(dc_err_o), 64'(b.err));
          end
          chk("ic_quiet", 64'({ic_rvalid_o, ic_rdata_o, ic_rlast_o, ic_err_o}), 64'd0);
        end
      end
    end
  end

  initial begin : stim
    bit seen;
    rst_n = 1'b0;
    ic_req_i = 1'b0; dc_req_i = 1'b0; ic_addr_i = '0; dc_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests after reset: IC, then DC; next tie again IC first
    expect_burst(0, 32'h0000_1000, 0, -1, LW - 1);
    expect_burst(1, 32'h0000_2008, 0, -1, LW - 1);
    tie_req(32'h0000_1000, 32'h0000_2008);
    wait_done("tie1");
    expect_burst(0, 32'h0000_3010, 0, -1, LW - 1);
    expect_burst(1, 32'h0000_403C, 0, -1, LW - 1);
    tie_req(32'h0000_3010, 32'h0000_403C);
    wait_done("tie2");

    // Single I-refill from a mid-line address
    expect_burst(0, 32'h0000_0124, 0, -1, LW - 1);
    single_req(0, 32'h0000_0124);
    wait_done("single_ic");

    // Slow arready
    cfg_ar_delay = 5;
    expect_burst(0, 32'h0000_0500, 5, -1, LW - 1);
    single_req(0, 32'h0000_0500);
    wait_done("slow_ar");
    cfg_ar_delay = 0;

    // Error response on beat index 2 of a D-refill
    cfg_err_beat = 2;
    expect_burst(1, 32'h0000_0600, 0, 2, LW - 1);
    single_req(1, 32'h0000_0604);
    wait_done("rresp_err");
    cfg_err_beat = -1;

    // Short burst: slave ends on beat index 2
    cfg_rlast_beat = 2;
    expect_burst(0, 32'h0000_0700, 0, -1, 2);
    single_req(0, 32'h0000_0700);
    wait_done("short_burst");
    cfg_rlast_beat = LW - 1;
    expect_burst(1, 32'h0000_0740, 0, -1, LW - 1);
    single_req(1, 32'h0000_0748);
    wait_done("after_short");

    // Reset mid-DATA, then a clean refill
    expect_burst(0, 32'h0000_0800, 0, -1, LW - 1);
    single_req(0, 32'h0000_0800);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (ic_rvalid_o) seen = 1;
    end
    if (!seen) fail_evt("mid_reset_no_beat");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle("mid_reset");
    ic_q.delete(); dc_q.delete(); ar_q.delete(); gnt_q.delete();
    expect_burst(0, 32'h0000_0900, 0, -1, LW - 1);
    single_req(0, 32'h0000_0900);
    wait_done("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
